// File: rtl/ppr_cache_pkg.sv
// Shared types, widths and helpers for the PPR cache controller.
package ppr_cache_pkg;

   typedef enum logic [2:0] {IDLE, RD, CMP, WR, RESP} state_t;

   localparam int             CNT_W   = 15;
   localparam logic [CNT_W-1:0] CNT_MAX = 15'h7FFF;
   localparam int             SYN_W   = 32;
   localparam int             DATA_W  = 272;
   localparam int             TYPE_W  = 2;
   localparam int             STAT_W  = 16;

   function automatic logic [TYPE_W-1:0] max_type(input logic [TYPE_W-1:0] a,
                                                  input logic [TYPE_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ppr_cache_ctrl_victim_sel.sv
// Combinational way selection: tag hit detect, first free way, and
// least-counted way as eviction victim when the set is full.
module ppr_victim_sel
   import ppr_cache_pkg::*;
#(
   parameter int N_WAY    = 4,
   parameter int TAG_SIZE = 20
)(
   input  logic [N_WAY-1:0]          i_valid,
   input  logic [TAG_SIZE*N_WAY-1:0] i_tag,
   input  logic [CNT_W*N_WAY-1:0]    i_cnt,
   input  logic [TAG_SIZE-1:0]       i_req_tag,
   output logic                      o_hit,
   output logic [$clog2(N_WAY)-1:0]  o_hit_way,
   output logic                      o_full,
   output logic [$clog2(N_WAY)-1:0]  o_victim_way
);

   localparam int WAY_W = $clog2(N_WAY);

   logic [N_WAY-1:0] w_match;
   logic [WAY_W-1:0] w_inv_way;
   logic [WAY_W-1:0] w_min_way;
   logic [CNT_W-1:0] w_min_cnt;

   for (genvar gi = 0; gi < N_WAY; gi++) begin : g_match
      assign w_match[gi] = i_valid[gi] && (i_tag[gi*TAG_SIZE +: TAG_SIZE] == i_req_tag);
   end

   // Scanning downward lets the lowest qualifying index overwrite last.
   always_comb begin
      o_hit_way = '0;
      w_inv_way = '0;
      for (int i = N_WAY - 1; i >= 0; i--) begin
         if (w_match[i])  o_hit_way = WAY_W'(i);
         if (!i_valid[i]) w_inv_way = WAY_W'(i);
      end
   end

   // Strict less-than keeps the lowest index on equal counts.
   always_comb begin
      w_min_way = '0;
      w_min_cnt = i_cnt[0 +: CNT_W];
      for (int i = 1; i < N_WAY; i++) begin
         if (i_cnt[i*CNT_W +: CNT_W] < w_min_cnt) begin
            w_min_cnt = i_cnt[i*CNT_W +: CNT_W];
            w_min_way = WAY_W'(i);
         end
      end
   end

   assign o_hit        = |w_match;
   assign o_full       = &i_valid;
   assign o_victim_way = o_full ? w_min_way : w_inv_way;

endmodule

// File: rtl/ppr_cache_ctrl.sv
// PPR cache controller: one read-modify-write of the indexed set per error report.
// Define PPR_CACHE_CTRL_STATS_EN to build the hit/miss/evict counters.
module ppr_cache_ctrl
   import ppr_cache_pkg::*;
#(
   parameter int               N_WAY     = 4,
   parameter int               ADDR_SIZE = 24,
   parameter int               IDX_SIZE  = 4,
   parameter int               TAG_SIZE  = 20,
   parameter logic [CNT_W-1:0] THRESH    = 15'd8
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_req_valid,
   output logic                         o_req_ready,
   input  logic [ADDR_SIZE-1:0]         i_req_addr,
   input  logic [TYPE_W-1:0]            i_req_type,
   input  logic [SYN_W-1:0]             i_req_syn,
   input  logic [DATA_W-1:0]            i_req_data,
   output logic                         o_rsp_valid,
   input  logic                         i_rsp_ready,
   output logic                         o_rsp_hit,
   output logic [$clog2(N_WAY)-1:0]     o_rsp_way,
   output logic [CNT_W-1:0]             o_rsp_cnt,
   output logic                         o_rsp_evict,
   output logic                         o_rsp_thresh,
   output logic                         o_sram_rden,
   output logic [IDX_SIZE-1:0]          o_sram_raddr,
   input  logic [N_WAY-1:0]             i_sram_rdata_valid,
   input  logic [TYPE_W*N_WAY-1:0]      i_sram_rdata_type,
   input  logic [SYN_W*N_WAY-1:0]       i_sram_rdata_syn,
   input  logic [TAG_SIZE*N_WAY-1:0]    i_sram_rdata_tag,
   input  logic [CNT_W*N_WAY-1:0]       i_sram_rdata_cnt,
   input  logic [DATA_W*N_WAY-1:0]      i_sram_rdata_data,
   output logic                         o_sram_wren,
   output logic [IDX_SIZE-1:0]          o_sram_waddr,
   output logic [$clog2(N_WAY)-1:0]     o_sram_wdata_line,
   output logic [TYPE_W-1:0]            o_sram_wdata_type,
   output logic [SYN_W-1:0]             o_sram_wdata_syn,
   output logic [TAG_SIZE-1:0]          o_sram_wdata_tag,
   output logic [CNT_W-1:0]             o_sram_wdata_cnt,
   output logic [DATA_W-1:0]            o_sram_wdata_data,
   output logic [STAT_W-1:0]            o_stat_hit,
   output logic [STAT_W-1:0]            o_stat_miss,
   output logic [STAT_W-1:0]            o_stat_evict
);

   localparam int WAY_W = $clog2(N_WAY);

   state_t              r_state;
   logic                r_req_ready;
   logic [IDX_SIZE-1:0] r_idx;
   logic [TAG_SIZE-1:0] r_tag;
   logic [TYPE_W-1:0]   r_type;
   logic [SYN_W-1:0]    r_syn;
   logic [DATA_W-1:0]   r_data;
   logic                r_sram_rden;
   logic                r_sram_wren;
   logic [TYPE_W-1:0]   r_wtype;
   logic                r_rsp_valid;
   logic                r_rsp_hit;
   logic [WAY_W-1:0]    r_rsp_way;
   logic [CNT_W-1:0]    r_rsp_cnt;
   logic                r_rsp_evict;
   logic                r_rsp_thresh;

   logic                w_hit;
   logic                w_full;
   logic [WAY_W-1:0]    w_hit_way;
   logic [WAY_W-1:0]    w_victim_way;
   logic [WAY_W-1:0]    w_way;
   logic [CNT_W-1:0]    w_old_cnt;
   logic [TYPE_W-1:0]   w_old_type;
   logic [CNT_W-1:0]    w_new_cnt;
   logic [TYPE_W-1:0]   w_new_type;
   logic                w_unused;

   ppr_victim_sel #(
      .N_WAY    (N_WAY),
      .TAG_SIZE (TAG_SIZE)
   ) u_victim_sel (
      .i_valid      (i_sram_rdata_valid),
      .i_tag        (i_sram_rdata_tag),
      .i_cnt        (i_sram_rdata_cnt),
      .i_req_tag    (r_tag),
      .o_hit        (w_hit),
      .o_hit_way    (w_hit_way),
      .o_full       (w_full),
      .o_victim_way (w_victim_way)
   );

   // Read data is only meaningful in CMP; these feed nothing but the CMP branch below.
   assign w_old_cnt  = i_sram_rdata_cnt[w_hit_way*CNT_W +: CNT_W];
   assign w_old_type = i_sram_rdata_type[w_hit_way*TYPE_W +: TYPE_W];
   assign w_way      = w_hit ? w_hit_way : w_victim_way;
   assign w_new_cnt  = !w_hit ? CNT_W'(1) :
                       (w_old_cnt == CNT_MAX) ? CNT_MAX : w_old_cnt + 1'b1;
   assign w_new_type = w_hit ? max_type(w_old_type, r_type) : r_type;

   // Stored syndrome and data are replaced by the new report, never merged.
   assign w_unused = ^{i_sram_rdata_syn, i_sram_rdata_data};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_req_ready  <= 1'b1;
         r_idx        <= '0;
         r_tag        <= '0;
         r_type       <= '0;
         r_syn        <= '0;
         r_data       <= '0;
         r_sram_rden  <= 1'b0;
         r_sram_wren  <= 1'b0;
         r_wtype      <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_hit    <= 1'b0;
         r_rsp_way    <= '0;
         r_rsp_cnt    <= '0;
         r_rsp_evict  <= 1'b0;
         r_rsp_thresh <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_req_valid) begin
                  r_idx       <= i_req_addr[IDX_SIZE-1:0];
                  r_tag       <= i_req_addr[ADDR_SIZE-1:IDX_SIZE];
                  r_type      <= i_req_type;
                  r_syn       <= i_req_syn;
                  r_data      <= i_req_data;
                  r_req_ready <= 1'b0;
                  r_sram_rden <= 1'b1;
                  r_state     <= RD;
               end
            end
            RD: begin
               r_sram_rden <= 1'b0;
               r_state     <= CMP;
            end
            CMP: begin
               r_rsp_hit    <= w_hit;
               r_rsp_way    <= w_way;
               r_rsp_cnt    <= w_new_cnt;
               r_rsp_evict  <= !w_hit && w_full;
               r_rsp_thresh <= (w_new_cnt >= THRESH);
               r_wtype      <= w_new_type;
               r_sram_wren  <= 1'b1;
               r_state      <= WR;
            end
            WR: begin
               r_sram_wren <= 1'b0;
               r_rsp_valid <= 1'b1;
               r_state     <= RESP;
            end
            RESP: begin
               if (i_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_req_ready <= 1'b1;
            end
         endcase
      end
   end

`ifdef PPR_CACHE_CTRL_STATS_EN
   logic [STAT_W-1:0] r_stat_hit;
   logic [STAT_W-1:0] r_stat_miss;
   logic [STAT_W-1:0] r_stat_evict;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stat_hit   <= '0;
         r_stat_miss  <= '0;
         r_stat_evict <= '0;
      end else if (r_state == RESP && i_rsp_ready) begin
         if (r_rsp_hit && r_stat_hit != '1)
            r_stat_hit <= r_stat_hit + 1'b1;
         if (!r_rsp_hit && r_stat_miss != '1)
            r_stat_miss <= r_stat_miss + 1'b1;
         if (r_rsp_evict && r_stat_evict != '1)
            r_stat_evict <= r_stat_evict + 1'b1;
      end
   end

   assign o_stat_hit   = r_stat_hit;
   assign o_stat_miss  = r_stat_miss;
   assign o_stat_evict = r_stat_evict;
`else
   assign o_stat_hit   = '0;
   assign o_stat_miss  = '0;
   assign o_stat_evict = '0;
`endif

   // The array samples wren on the same edge as reset, so a reset landing in
   // WR must suppress the strobe to keep the dropped report uncommitted.
   assign o_sram_wren       = r_sram_wren && rst_n;
   assign o_req_ready       = r_req_ready;
   assign o_sram_rden       = r_sram_rden;
   assign o_sram_raddr      = r_idx;
   assign o_sram_waddr      = r_idx;
   assign o_sram_wdata_line = r_rsp_way;
   assign o_sram_wdata_type = r_wtype;
   assign o_sram_wdata_syn  = r_syn;
   assign o_sram_wdata_tag  = r_tag;
   assign o_sram_wdata_cnt  = r_rsp_cnt;
   assign o_sram_wdata_data = r_data;
   assign o_rsp_valid       = r_rsp_valid;
   assign o_rsp_hit         = r_rsp_hit;
   assign o_rsp_way         = r_rsp_way;
   assign o_rsp_cnt         = r_rsp_cnt;
   assign o_rsp_evict       = r_rsp_evict;
   assign o_rsp_thresh      = r_rsp_thresh;

endmodule

// File: tb/tb_ppr_cache_ctrl.sv
// Directed bench for ppr_cache_ctrl with a behavioural 4-way x 16-set SRAM.
// Covers PPR_CACHE_CTRL_STATS_EN both defined and undefined.
module tb_ppr_cache_ctrl;
   import ppr_cache_pkg::*;

   typedef struct packed {
      logic          valid;
      logic [1:0]    typ;
      logic [31:0]   syn;
      logic [19:0]   tag;
      logic [14:0]   cnt;
      logic [271:0]  data;
   } ent_t;

   typedef struct {
      logic [23:0] addr;
      logic [1:0]  typ;
      int          hold;
      logic        e_hit;
      logic [1:0]  e_way;
      logic [14:0] e_cnt;
      logic [1:0]  e_type;
      logic        e_evict;
      logic        e_thresh;
   } vec_t;

   logic          clk, rst_n;
   logic          i_req_valid, i_rsp_ready;
   logic [23:0]   i_req_addr;
   logic [1:0]    i_req_type;
   logic [31:0]   i_req_syn;
   logic [271:0]  i_req_data;
   logic          o_req_ready, o_rsp_valid, o_rsp_hit, o_rsp_evict, o_rsp_thresh;
   logic [1:0]    o_rsp_way;
   logic [14:0]   o_rsp_cnt;
   logic          o_sram_rden, o_sram_wren;
   logic [3:0]    o_sram_raddr, o_sram_waddr;
   logic [3:0]    rd_valid;
   logic [7:0]    rd_type;
   logic [127:0]  rd_syn;
   logic [79:0]   rd_tag;
   logic [59:0]   rd_cnt;
   logic [1087:0] rd_data;
   logic [1:0]    o_sram_wdata_line, o_sram_wdata_type;
   logic [31:0]   o_sram_wdata_syn;
   logic [19:0]   o_sram_wdata_tag;
   logic [14:0]   o_sram_wdata_cnt;
   logic [271:0]  o_sram_wdata_data;
   logic [15:0]   o_stat_hit, o_stat_miss, o_stat_evict;

   ppr_cache_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_addr(i_req_addr),
      .i_req_type(i_req_type), .i_req_syn(i_req_syn), .i_req_data(i_req_data),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_hit(o_rsp_hit),
      .o_rsp_way(o_rsp_way), .o_rsp_cnt(o_rsp_cnt), .o_rsp_evict(o_rsp_evict),
      .o_rsp_thresh(o_rsp_thresh),
      .o_sram_rden(o_sram_rden), .o_sram_raddr(o_sram_raddr),
      .i_sram_rdata_valid(rd_valid), .i_sram_rdata_type(rd_type), .i_sram_rdata_syn(rd_syn),
      .i_sram_rdata_tag(rd_tag), .i_sram_rdata_cnt(rd_cnt), .i_sram_rdata_data(rd_data),
      .o_sram_wren(o_sram_wren), .o_sram_waddr(o_sram_waddr),
      .o_sram_wdata_line(o_sram_wdata_line), .o_sram_wdata_type(o_sram_wdata_type),
      .o_sram_wdata_syn(o_sram_wdata_syn), .o_sram_wdata_tag(o_sram_wdata_tag),
      .o_sram_wdata_cnt(o_sram_wdata_cnt), .o_sram_wdata_data(o_sram_wdata_data),
      .o_stat_hit(o_stat_hit), .o_stat_miss(o_stat_miss), .o_stat_evict(o_stat_evict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural SRAM: registered read, data visible the cycle after rden, X otherwise.
   ent_t       mem [16][4];
   logic       rd_ok;
   logic [3:0] rd_set;
   logic       tb_clr, tb_pl;
   logic [3:0] tb_set;
   logic [1:0] tb_way;
   ent_t       tb_ent;

   always @(posedge clk) begin
      rd_ok  <= o_sram_rden;
      rd_set <= o_sram_raddr;
      if (tb_clr) begin
         for (int s = 0; s < 16; s++)
            for (int w = 0; w < 4; w++)
               mem[s][w] <= '0;
      end else if (tb_pl) begin
         mem[tb_set][tb_way] <= tb_ent;
      end else if (o_sram_wren) begin
         mem[o_sram_waddr][o_sram_wdata_line] <= '{1'b1, o_sram_wdata_type, o_sram_wdata_syn,
                                                 o_sram_wdata_tag, o_sram_wdata_cnt,
                                                 o_sram_wdata_data};
      end
   end

   always_comb begin
      rd_valid = 'x;
      rd_type  = 'x;
      rd_syn   = 'x;
      rd_tag   = 'x;
      rd_cnt   = 'x;
      rd_data  = 'x;
      if (rd_ok) begin
         for (int w = 0; w < 4; w++) begin
            rd_valid[w]            = mem[rd_set][w].valid;
            rd_type[w*2 +: 2]      = mem[rd_set][w].typ;
            rd_syn[w*32 +: 32]     = mem[rd_set][w].syn;
            rd_tag[w*20 +: 20]     = mem[rd_set][w].tag;
            rd_cnt[w*15 +: 15]     = mem[rd_set][w].cnt;
            rd_data[w*272 +: 272]  = mem[rd_set][w].data;
         end
      end
   end

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Captured per transaction
   int           rd_cyc, wr_cyc, rv_cyc, rd_n, wr_n;
   logic [3:0]   cap_raddr, cap_waddr;
   logic [1:0]   cap_line, cap_wtype, cap_way;
   logic [19:0]  cap_wtag;
   logic [14:0]  cap_wcnt, cap_rcnt;
   logic [31:0]  cap_wsyn, cur_syn;
   logic [271:0] cap_wdata, cur_data;
   logic         cap_hit, cap_evict, cap_thresh;

   task automatic preload(input logic [3:0] s, input logic [1:0] w, input logic [19:0] tag,
                          input logic [14:0] cnt, input logic [1:0] typ);
      @(negedge clk);
      tb_pl = 1'b1; tb_set = s; tb_way = w;
      tb_ent = '{1'b1, typ, 32'hDEAD0000, tag, cnt, {17{16'hBEEF}}};
      @(negedge clk);
      tb_pl = 1'b0;
   endtask

   task automatic run_req(input logic [23:0] a, input logic [1:0] t, input int hold,
                          input string nm);
      int   cyc;
      logic stable;
      @(negedge clk);
      cur_syn     = {8'h5A, a};
      cur_data    = {17{a[15:0] ^ 16'h3C3C}};
      i_req_addr  = a;
      i_req_type  = t;
      i_req_syn   = cur_syn;
      i_req_data  = cur_data;
      i_req_valid = 1'b1;
      i_rsp_ready = 1'b0;
      #1 chk({nm, " req_ready"}, 64'(o_req_ready), 64'd1);
      @(posedge clk);
      #1;
      i_req_valid = 1'b0;
      i_req_syn   = ~cur_syn;
      i_req_data  = ~cur_data;
      rd_cyc = -1; wr_cyc = -1; rv_cyc = -1; rd_n = 0; wr_n = 0; cyc = 0;
      while (rv_cyc < 0 && cyc < 12) begin
         @(negedge clk);
         cyc++;
         if (o_sram_rden) begin
            rd_n++; rd_cyc = cyc; cap_raddr = o_sram_raddr;
         end
         if (o_sram_wren) begin
            wr_n++; wr_cyc = cyc;
            cap_waddr = o_sram_waddr;  cap_line  = o_sram_wdata_line;
            cap_wtype = o_sram_wdata_type; cap_wtag = o_sram_wdata_tag;
            cap_wcnt  = o_sram_wdata_cnt;  cap_wsyn = o_sram_wdata_syn;
            cap_wdata = o_sram_wdata_data;
         end
         if (o_rsp_valid) begin
            rv_cyc = cyc;
            cap_hit = o_rsp_hit; cap_way = o_rsp_way; cap_rcnt = o_rsp_cnt;
            cap_evict = o_rsp_evict; cap_thresh = o_rsp_thresh;
         end
      end
      chk({nm, " rsp_valid_cycle"}, 64'(rv_cyc), 64'd4);
      stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         if (o_rsp_valid !== 1'b1 || o_rsp_hit !== cap_hit || o_rsp_way !== cap_way ||
             o_rsp_cnt !== cap_rcnt || o_rsp_evict !== cap_evict ||
             o_rsp_thresh !== cap_thresh || o_req_ready !== 1'b0 ||
             o_sram_rden !== 1'b0 || o_sram_wren !== 1'b0)
            stable = 1'b0;
      end
      if (hold > 0) chk({nm, " stall_stable"}, 64'(stable), 64'd1);
      i_rsp_ready = 1'b1;
      @(posedge clk);
      #1 i_rsp_ready = 1'b0;
      @(negedge clk);
      chk({nm, " idle_ready"}, 64'(o_req_ready), 64'd1);
      chk({nm, " rsp_dropped"}, 64'(o_rsp_valid), 64'd0);
      $display("txn %s addr=%06h hit=%0d way=%0d cnt=%0h evict=%0d thresh=%0d wtype=%0d",
               nm, a, cap_hit, cap_way, cap_rcnt, cap_evict, cap_thresh, cap_wtype);
   endtask

   vec_t vt [9];
   int   e_hits, e_miss, e_ev;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vt[0] = '{24'h123453, 2'd1, 0,  1'b0, 2'd0, 15'd1,      2'd1, 1'b0, 1'b0};
      vt[1] = '{24'h123453, 2'd2, 0,  1'b1, 2'd0, 15'd2,      2'd2, 1'b0, 1'b0};
      vt[2] = '{24'h123453, 2'd0, 10, 1'b1, 2'd0, 15'd3,      2'd2, 1'b0, 1'b0};
      vt[3] = '{24'h543213, 2'd3, 0,  1'b0, 2'd1, 15'd1,      2'd3, 1'b0, 1'b0};
      vt[4] = '{24'hFFFFF5, 2'd1, 0,  1'b0, 2'd1, 15'd1,      2'd1, 1'b1, 1'b0};
      vt[5] = '{24'hFFFFF5, 2'd0, 0,  1'b1, 2'd1, 15'd2,      2'd1, 1'b0, 1'b0};
      vt[6] = '{24'h077777, 2'd0, 0,  1'b1, 2'd0, 15'h7FFF,   2'd1, 1'b0, 1'b1};
      vt[7] = '{24'h222228, 2'd1, 0,  1'b1, 2'd2, 15'd8,      2'd3, 1'b0, 1'b1};
      vt[8] = '{24'h333338, 2'd2, 0,  1'b0, 2'd0, 15'd1,      2'd2, 1'b0, 1'b0};

      rst_n = 1'b0; i_req_valid = 1'b0; i_rsp_ready = 1'b0;
      i_req_addr = '0; i_req_type = '0; i_req_syn = '0; i_req_data = '0;
      tb_clr = 1'b1; tb_pl = 1'b0; tb_set = '0; tb_way = '0; tb_ent = '0;
      @(negedge clk);
      tb_clr = 1'b0;
      preload(4'd5, 2'd0, 20'h00A01, 15'd3, 2'd0);
      preload(4'd5, 2'd1, 20'h00A02, 15'd1, 2'd0);
      preload(4'd5, 2'd2, 20'h00A03, 15'd2, 2'd0);
      preload(4'd5, 2'd3, 20'h00A04, 15'd1, 2'd0);
      preload(4'd7, 2'd0, 20'h07777, 15'h7FFF, 2'd1);
      preload(4'd8, 2'd1, 20'h11111, 15'd5, 2'd0);
      preload(4'd8, 2'd2, 20'h22222, 15'd7, 2'd3);

      chk("rst rsp_valid",  64'(o_rsp_valid),  64'd0);
      chk("rst rden",       64'(o_sram_rden),  64'd0);
      chk("rst wren",       64'(o_sram_wren),  64'd0);
      chk("rst req_ready",  64'(o_req_ready),  64'd1);
      chk("rst rsp_cnt",    64'(o_rsp_cnt),    64'd0);
      chk("rst raddr",      64'(o_sram_raddr), 64'd0);
      chk("rst waddr",      64'(o_sram_waddr), 64'd0);
      chk("rst wdata_cnt",  64'(o_sram_wdata_cnt), 64'd0);
      chk("rst stat_hit",   64'(o_stat_hit),   64'd0);
      rst_n = 1'b1;

      e_hits = 0; e_miss = 0; e_ev = 0;
      for (int i = 0; i < 9; i++) begin
         string nm;
         nm = $sformatf("v%0d", i);
         run_req(vt[i].addr, vt[i].typ, vt[i].hold, nm);
         chk({nm, " rd_cycle"},   64'(rd_cyc),    64'd1);
         chk({nm, " rd_count"},   64'(rd_n),      64'd1);
         chk({nm, " raddr"},      64'(cap_raddr), 64'(vt[i].addr[3:0]));
         chk({nm, " wr_cycle"},   64'(wr_cyc),    64'd3);
         chk({nm, " wr_count"},   64'(wr_n),      64'd1);
         chk({nm, " waddr"},      64'(cap_waddr), 64'(vt[i].addr[3:0]));
         chk({nm, " wline"},      64'(cap_line),  64'(vt[i].e_way));
         chk({nm, " wtag"},       64'(cap_wtag),  64'(vt[i].addr[23:4]));
         chk({nm, " wcnt"},       64'(cap_wcnt),  64'(vt[i].e_cnt));
         chk({nm, " wtype"},      64'(cap_wtype), 64'(vt[i].e_type));
         chk({nm, " wsyn"},       64'(cap_wsyn),  64'(cur_syn));
         chk({nm, " wdata"},      64'(cap_wdata === cur_data), 64'd1);
         chk({nm, " rsp_hit"},    64'(cap_hit),   64'(vt[i].e_hit));
         chk({nm, " rsp_way"},    64'(cap_way),   64'(vt[i].e_way));
         chk({nm, " rsp_cnt"},    64'(cap_rcnt),  64'(vt[i].e_cnt));
         chk({nm, " rsp_evict"},  64'(cap_evict), 64'(vt[i].e_evict));
         chk({nm, " rsp_thresh"}, 64'(cap_thresh), 64'(vt[i].e_thresh));
         if (vt[i].e_hit) e_hits++; else e_miss++;
         if (vt[i].e_evict) e_ev++;
      end

`ifdef PPR_CACHE_CTRL_STATS_EN
      chk("stat_hit",   64'(o_stat_hit),   64'(e_hits));
      chk("stat_miss",  64'(o_stat_miss),  64'(e_miss));
      chk("stat_evict", 64'(o_stat_evict), 64'(e_ev));
`else
      chk("stat_hit_tied",   64'(o_stat_hit),   64'd0);
      chk("stat_miss_tied",  64'(o_stat_miss),  64'd0);
      chk("stat_evict_tied", 64'(o_stat_evict), 64'd0);
`endif

      // Reset while the write strobe is up: the report must vanish.
      @(negedge clk);
      i_req_addr = 24'hABCDE9; i_req_type = 2'd1; i_req_valid = 1'b1;
      @(posedge clk);
      #1 i_req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rstwr in_wr", 64'(o_sram_wren), 64'd1);
      rst_n = 1'b0;
      #1 chk("rstwr wren_blocked", 64'(o_sram_wren), 64'd0);
      @(posedge clk);
      #1;
      chk("rstwr idle_ready", 64'(o_req_ready), 64'd1);
      chk("rstwr rsp_valid",  64'(o_rsp_valid), 64'd0);
      chk("rstwr rden",       64'(o_sram_rden), 64'd0);
      chk("rstwr stat_miss",  64'(o_stat_miss), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_req(24'hABCDE9, 2'd1, 0, "rerun");
      chk("rerun rsp_hit", 64'(cap_hit),  64'd0);
      chk("rerun rsp_way", 64'(cap_way),  64'd0);
      chk("rerun rsp_cnt", 64'(cap_rcnt), 64'd1);
`ifdef PPR_CACHE_CTRL_STATS_EN
      chk("rerun stat_miss", 64'(o_stat_miss), 64'd1);
      chk("rerun stat_hit",  64'(o_stat_hit),  64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ppr_cache_ctrl.md
Name: ppr_cache_ctrl

Overview:
- Initiator side of the 6T SRAM PPR cache. Drives the SRAM read and write ports; the array is the responder.
- Accepts error reports (address, type, syndrome, 272-bit data) through a valid/ready handshake.
- Per report: one read-modify-write of the indexed set. Hit increments the way's counter; miss allocates a way and evicts if needed.
- Returns per-report status to the RAS manager upstream.

Parameters:
N_WAY, 4, ways per set (power of 2, >=2)
ADDR_SIZE, 24, request address width
IDX_SIZE, 4, set index width; index = addr[IDX_SIZE-1:0]
TAG_SIZE, 20, tag width; tag = addr[ADDR_SIZE-1:IDX_SIZE]; must equal ADDR_SIZE-IDX_SIZE
THRESH, 15'd8, counter value at which rsp_thresh asserts

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  report valid
req_ready  out  1  high only in IDLE
req_addr  in  ADDR_SIZE  faulting address
req_type  in  2  error type
req_syn  in  32  syndrome
req_data  in  272  codeword
rsp_valid  out  1  result valid; held until rsp_ready
rsp_ready  in  1  result accepted
rsp_hit  out  1  1=hit, 0=allocate
rsp_way  out  log2(N_WAY)  way written
rsp_cnt  out  15  counter value written
rsp_evict  out  1  miss replaced a valid entry
rsp_thresh  out  1  rsp_cnt >= THRESH
sram_rden  out  1  read strobe
sram_raddr  out  IDX_SIZE  read set
sram_rdata_valid  in  N_WAY  per-way valid
sram_rdata_type  in  2*N_WAY  per-way type
sram_rdata_syn  in  32*N_WAY  per-way syndrome
sram_rdata_tag  in  TAG_SIZE*N_WAY  per-way tag
sram_rdata_cnt  in  15*N_WAY  per-way count
sram_rdata_data  in  272*N_WAY  per-way data
sram_wren  out  1  write strobe
sram_waddr  out  IDX_SIZE  write set
sram_wdata_line  out  log2(N_WAY)  write way
sram_wdata_type  out  2  type
sram_wdata_syn  out  32  syndrome
sram_wdata_tag  out  TAG_SIZE  tag
sram_wdata_cnt  out  15  count
sram_wdata_data  out  272  data

Behaviour:
- Reset: FSM=IDLE. rsp_valid, sram_rden, sram_wren, all rsp_* and sram_* address/data outputs = 0. Synchronous; any state returns to IDLE; an in-flight report is dropped with no write.
- FSM: IDLE -> RD -> CMP -> WR -> RESP -> IDLE.
- IDLE: req_ready=1. On req_valid, latch request; go to RD.
- RD: sram_rden=1, sram_raddr=idx. Array returns data one cycle later.
- CMP: sample sram_rdata_* this cycle only. Read data is Z/X outside CMP and must not be used.
  - hit = any way with valid && tag match; lowest matching index wins.
  - On miss, victim = lowest-index invalid way. If all ways are valid, victim = way with minimum cnt (ties to lowest index), and evict=1.
  - Register the decision; no SRAM access in CMP.
- WR: sram_wren=1, sram_rden=0 (the array gives read priority, so the two must never overlap). waddr=idx, wdata_line=way, wdata_tag=tag, wdata_syn=req_syn, wdata_data=req_data.
  - Hit: cnt = stored cnt+1, saturating at 15'h7FFF. type = max(stored type, req_type).
  - Miss: cnt=1, type=req_type.
- RESP: rsp_valid=1 with fields stable until rsp_ready; on handshake go to IDLE.
- Latency: request accept at cycle 0; rsp_valid at cycle 4 minimum. One report in flight; throughput 1 per 5 cycles.
- Strobes are single-cycle; never high outside RD/WR.

Optional Feature:
- Macro PPR_CACHE_CTRL_STATS_EN.
- Defined: adds outputs stat_hit, stat_miss, stat_evict (each 16 bits). Each is a saturating counter incremented on the RESP handshake; cleared by reset.
- Undefined: the ports exist but are tied to 0, and no counters are built.

Decomposition:
- Package ppr_cache_pkg:
  - state enum {IDLE,RD,CMP,WR,RESP}
  - CNT_W=15, CNT_MAX=15'h7FFF, SYN_W=32, DATA_W=272, TYPE_W=2
  - function max_type()
- Sub-module ppr_victim_sel: combinational hit detect, invalid-way and minimum-count victim pick; parameterised by N_WAY and TAG_SIZE.

Test Plan:
- Empty array, req_addr=24'h12345_3 -> idx=3, rden at cycle 1, wren at cycle 3 with line=0, cnt=1, tag=20'h12345; rsp_hit=0, rsp_evict=0.
- Same address repeated twice -> rsp_hit=1, way=0, cnt=2 then 3; type = max of old and new (old 1, new 2 -> 2).
- Set 5 filled with 4 tags at counts 3,1,2,1, then a new tag -> victim way1, rsp_evict=1, cnt=1.
- Stored cnt=15'h7FFF, hit -> written cnt=15'h7FFF; rsp_thresh=1. Also: cnt 7 -> 8 gives rsp_thresh=1.
- rsp_ready=0 for 10 cycles -> rsp_valid and fields stable, req_ready=0, no rden/wren; release -> IDLE.
- rst_n low during WR -> no write committed, next cycle IDLE; a rerun of the same request misses. With PPR_CACHE_CTRL_STATS_EN: 2 miss + 1 hit -> stat_miss=2, stat_hit=1.
